tap_bank_loader: RTL and testbench

TAP_BANK_LOADER -- requirements
Module: tap_bank_loader

---
 rtl/tap_bank_loader.sv | 145 ++++++++++++++
 tb/tb_tap_bank_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_bank_loader.sv
// tap_bank_loader: double-buffered coefficient RAM filled by address/data bursts into the shadow bank.
// Define TAP_SWAP_SYNC_EN to hold each bank swap until frame_sync; otherwise the swap follows the burst close.
module tap_bank_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk_100m,
    input  logic              rst_100m,
    input  logic              tap_wr_cmd,
    input  logic [31:0]       tap_wr_addr,
    input  logic              tap_wr_vld,
    input  logic [DATA_W-1:0] tap_wr_data,
    input  logic              frame_sync,
    input  logic [ADDR_W-1:0] coef_rd_addr,
    output logic [DATA_W-1:0] coef_rd_data,
    output logic              active_bank,
    output logic              load_done,
    output logic              load_err,
    output logic [31:0]       tap_vld_cnt,
    output logic [15:0]       last_word_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, PEND_SWAP} state_t;

    state_t            state;
    logic              cmd_q;
    logic              cmd_armed;
    logic [ADDR_W-1:0] base;
    logic [15:0]       word_idx;
    logic              base_bad;
    logic              ovf;

    logic              cmd_rise;
    logic              cmd_fall;
    logic              start;
    logic              strobe;
    logic              rejected_now;
    logic              in_range;
    logic              wr_en;
    logic              ovf_now;
    logic              close_ok;
    logic              swap_now;
    logic              wr_bank;
    logic [31:0]       wr_sum;

    logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

    always_comb begin
        cmd_rise     = tap_wr_cmd && !cmd_q && cmd_armed;
        cmd_fall     = !tap_wr_cmd && cmd_q;
        start        = cmd_rise && (state != LOAD);
        strobe       = tap_wr_vld && tap_wr_cmd && (start || state == LOAD);
        rejected_now = start ? ((tap_wr_addr >> ADDR_W) != 32'd0) : base_bad;
        // The rise cycle addresses from the live bus because base is not captured yet.
        wr_sum       = start ? 32'(tap_wr_addr[ADDR_W-1:0]) : 32'(base) + 32'(word_idx);
        in_range     = (wr_sum >> ADDR_W) == 32'd0;
        wr_en        = strobe && !rejected_now && in_range;
        ovf_now      = strobe && !rejected_now && !in_range;
        close_ok     = (state == LOAD) && cmd_fall && !base_bad && !ovf && (word_idx != 16'd0);
`ifdef TAP_SWAP_SYNC_EN
        swap_now     = (state == PEND_SWAP) && frame_sync;
`else
        swap_now     = close_ok;
`endif
        // A swap in this cycle turns the currently read bank into the next shadow.
        wr_bank      = swap_now ? active_bank : !active_bank;
    end

    // NOTE: the RAM has no reset so it maps onto block RAM; its contents survive rst_100m.
    always_ff @(posedge clk_100m) begin
        if (wr_en && !rst_100m)
            mem[{wr_bank, wr_sum[ADDR_W-1:0]}] <= tap_wr_data;
    end

    always_ff @(posedge clk_100m) begin
        if (rst_100m)
            coef_rd_data <= '0;
        else
            coef_rd_data <= mem[{active_bank, coef_rd_addr}];
    end

    always_ff @(posedge clk_100m) begin
        if (rst_100m) begin
            state         <= IDLE;
            cmd_q         <= 1'b0;
            cmd_armed     <= 1'b0;
            base          <= '0;
            word_idx      <= '0;
            base_bad      <= 1'b0;
            ovf           <= 1'b0;
            active_bank   <= 1'b0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            tap_vld_cnt   <= '0;
            last_word_cnt <= '0;
        end else begin
            cmd_q <= tap_wr_cmd;
            // cmd must be seen low once after reset before a rise counts.
            if (!tap_wr_cmd)
                cmd_armed <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;

            if (swap_now) begin
                active_bank <= !active_bank;
                load_done   <= 1'b1;
                tap_vld_cnt <= tap_vld_cnt + 32'd1;
            end

            if (start) begin
                state    <= LOAD;
                base     <= tap_wr_addr[ADDR_W-1:0];
                base_bad <= rejected_now;
                ovf      <= ovf_now;
                word_idx <= strobe ? 16'd1 : 16'd0;
            end else begin
                case (state)
                    LOAD: begin
                        if (cmd_fall) begin
                            last_word_cnt <= word_idx;
                            if (close_ok) begin
`ifdef TAP_SWAP_SYNC_EN
                                state <= PEND_SWAP;
`else
                                state <= IDLE;
`endif
                            end else begin
                                load_err <= 1'b1;
                                state    <= IDLE;
                            end
                        end else if (strobe) begin
                            word_idx <= (word_idx == 16'hFFFF) ? word_idx : word_idx + 16'd1;
                            if (ovf_now)
                                ovf <= 1'b1;
                        end
                    end
                    PEND_SWAP: begin
                        if (frame_sync)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tap_bank_loader.sv
// Directed bench for tap_bank_loader; expectations follow the build's TAP_SWAP_SYNC_EN setting.
module tb_tap_bank_loader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
`ifdef TAP_SWAP_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic              clk_100m = 1'b0;
    logic              rst_100m;
    logic              tap_wr_cmd;
    logic [31:0]       tap_wr_addr;
    logic              tap_wr_vld;
    logic [DATA_W-1:0] tap_wr_data;
    logic              frame_sync;
    logic [ADDR_W-1:0] coef_rd_addr;
    logic [DATA_W-1:0] coef_rd_data;
    logic              active_bank;
    logic              load_done;
    logic              load_err;
    logic [31:0]       tap_vld_cnt;
    logic [15:0]       last_word_cnt;

    int vec_cnt     = 0;
    int miscompares = 0;
    int done_seen   = 0;
    int err_seen    = 0;
    int done_mark;
    int err_mark;

    tap_bank_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_100m     (clk_100m),
        .rst_100m     (rst_100m),
        .tap_wr_cmd   (tap_wr_cmd),
        .tap_wr_addr  (tap_wr_addr),
        .tap_wr_vld   (tap_wr_vld),
        .tap_wr_data  (tap_wr_data),
        .frame_sync   (frame_sync),
        .coef_rd_addr (coef_rd_addr),
        .coef_rd_data (coef_rd_data),
        .active_bank  (active_bank),
        .load_done    (load_done),
        .load_err     (load_err),
        .tap_vld_cnt  (tap_vld_cnt),
        .last_word_cnt(last_word_cnt)
    );

    always #5 clk_100m = ~clk_100m;

    // Pulse counters see the value held through the previous cycle.
    always @(posedge clk_100m) begin
        if (load_done) done_seen++;
        if (load_err)  err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic mark();
        done_mark = done_seen;
        err_mark  = err_seen;
    endtask

    task automatic burst(input logic [31:0] addr, input int n, input logic [31:0] d0);
        @(negedge clk_100m);
        tap_wr_cmd  = 1'b1;
        tap_wr_addr = addr;
        tap_wr_vld  = 1'b1;
        tap_wr_data = d0;
        for (int i = 1; i < n; i++) begin
            @(negedge clk_100m);
            tap_wr_data = d0 + 32'(i);
        end
        @(negedge clk_100m);
        tap_wr_cmd = 1'b0;
        tap_wr_vld = 1'b0;
    endtask

    task automatic close_check(input string tag, input bit ok);
        @(negedge clk_100m);
        check({tag, "_done_at_close"}, 32'(load_done), (SYNC ? 32'd0 : 32'(ok)));
        check({tag, "_err_at_close"}, 32'(load_err), 32'(!ok));
    endtask

    task automatic do_sync();
        @(negedge clk_100m);
        frame_sync = 1'b1;
        @(negedge clk_100m);
        frame_sync = 1'b0;
        @(negedge clk_100m);
        @(negedge clk_100m);
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        @(negedge clk_100m);
        coef_rd_addr = addr;
        @(negedge clk_100m);
        check(tag, coef_rd_data, exp);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_active"}, 32'(active_bank), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_err"}, 32'(load_err), 32'd0);
        check({tag, "_cnt"}, tap_vld_cnt, 32'd0);
        check({tag, "_last"}, 32'(last_word_cnt), 32'd0);
        check({tag, "_rd"}, coef_rd_data, 32'd0);
    endtask

    initial begin
        rst_100m     = 1'b1;
        tap_wr_cmd   = 1'b0;
        tap_wr_addr  = '0;
        tap_wr_vld   = 1'b0;
        tap_wr_data  = '0;
        frame_sync   = 1'b0;
        coef_rd_addr = '0;
        repeat (3) @(negedge clk_100m);
        check_zero_outputs("reset");
        rst_100m = 1'b0;

        // Basic load into bank 1.
        mark();
        burst(32'h0, 4, 32'hA0);
        close_check("basic", 1'b1);
        do_sync();
        check("basic_done_cnt", 32'(done_seen - done_mark), 32'd1);
        check("basic_active", 32'(active_bank), 32'd1);
        check("basic_vld_cnt", tap_vld_cnt, 32'd1);
        check("basic_last", 32'(last_word_cnt), 32'd4);
        for (int i = 0; i < 4; i++)
            read_check("basic_rd", ADDR_W'(i), 32'hA0 + 32'(i));

        // Fill bank 0 so bank 1 becomes the shadow holding A0..A3.
        burst(32'h0, 2, 32'hE0);
        close_check("fill", 1'b1);
        do_sync();
        check("fill_active", 32'(active_bank), 32'd0);
        read_check("fill_rd", 10'h001, 32'hE1);

        // Out-of-range base: rejected, nothing written.
        mark();
        burst(32'h0000_0400, 2, 32'hB0);
        close_check("reject", 1'b0);
        do_sync();
        check("reject_err_cnt", 32'(err_seen - err_mark), 32'd1);
        check("reject_done_cnt", 32'(done_seen - done_mark), 32'd0);
        check("reject_active", 32'(active_bank), 32'd0);
        check("reject_vld_cnt", tap_vld_cnt, 32'd2);

        // Overflow at the top of the bank: two kept, two dropped, no wrap.
        mark();
        burst(32'h3FE, 4, 32'hC0);
        close_check("ovf", 1'b0);
        do_sync();
        check("ovf_err_cnt", 32'(err_seen - err_mark), 32'd1);
        check("ovf_done_cnt", 32'(done_seen - done_mark), 32'd0);
        check("ovf_last", 32'(last_word_cnt), 32'd4);
        check("ovf_active", 32'(active_bank), 32'd0);

        // Single word burst exposes bank 1.
        burst(32'h200, 1, 32'hD0);
        close_check("single", 1'b1);
        do_sync();
        check("single_active", 32'(active_bank), 32'd1);
        check("single_vld_cnt", tap_vld_cnt, 32'd3);
        check("single_last", 32'(last_word_cnt), 32'd1);
        read_check("bank1_0", 10'h000, 32'hA0);
        read_check("bank1_1", 10'h001, 32'hA1);
        read_check("bank1_3fe", 10'h3FE, 32'hC0);
        read_check("bank1_3ff", 10'h3FF, 32'hC1);
        read_check("bank1_200", 10'h200, 32'hD0);

        // Second burst before frame_sync.
        mark();
        burst(32'h20, 2, 32'h11);
        close_check("cancel_a", 1'b1);
        burst(32'h20, 2, 32'h21);
        close_check("cancel_b", 1'b1);
        @(negedge clk_100m);
        check("cancel_pending_done", 32'(done_seen - done_mark), (SYNC ? 32'd0 : 32'd2));
        do_sync();
        check("cancel_done_cnt", 32'(done_seen - done_mark), (SYNC ? 32'd1 : 32'd2));
        check("cancel_active", 32'(active_bank), (SYNC ? 32'd0 : 32'd1));
        check("cancel_vld_cnt", tap_vld_cnt, (SYNC ? 32'd4 : 32'd5));
        read_check("cancel_rd0", 10'h020, 32'h21);
        read_check("cancel_rd1", 10'h021, 32'h22);

        // Empty burst, then stray strobes with cmd low.
        mark();
        @(negedge clk_100m);
        tap_wr_cmd  = 1'b1;
        tap_wr_addr = 32'h10;
        repeat (5) @(negedge clk_100m);
        tap_wr_cmd = 1'b0;
        @(negedge clk_100m);
        check("empty_err", 32'(load_err), 32'd1);
        check("empty_last", 32'(last_word_cnt), 32'd0);
        tap_wr_vld  = 1'b1;
        tap_wr_data = 32'hFF;
        repeat (3) @(negedge clk_100m);
        tap_wr_vld = 1'b0;
        repeat (2) @(negedge clk_100m);
        check("stray_err_cnt", 32'(err_seen - err_mark), 32'd1);
        check("stray_done_cnt", 32'(done_seen - done_mark), 32'd0);
        check("stray_vld_cnt", tap_vld_cnt, (SYNC ? 32'd4 : 32'd5));

        // Reset after two of four words; cmd stays high across release.
        @(negedge clk_100m);
        tap_wr_cmd  = 1'b1;
        tap_wr_addr = 32'h30;
        tap_wr_vld  = 1'b1;
        tap_wr_data = 32'h31;
        @(negedge clk_100m);
        tap_wr_data = 32'h32;
        @(negedge clk_100m);
        tap_wr_vld = 1'b0;
        rst_100m   = 1'b1;
        mark();
        repeat (2) @(negedge clk_100m);
        check_zero_outputs("midrst");
        rst_100m    = 1'b0;
        tap_wr_vld  = 1'b1;
        tap_wr_data = 32'h99;
        repeat (2) @(negedge clk_100m);
        tap_wr_cmd = 1'b0;
        tap_wr_vld = 1'b0;
        repeat (3) @(negedge clk_100m);
        check("midrst_done_cnt", 32'(done_seen - done_mark), 32'd0);
        check("midrst_err_cnt", 32'(err_seen - err_mark), 32'd0);
        check("midrst_vld_cnt", tap_vld_cnt, 32'd0);

        burst(32'h30, 4, 32'h41);
        close_check("after_rst", 1'b1);
        do_sync();
        check("after_rst_done_cnt", 32'(done_seen - done_mark), 32'd1);
        check("after_rst_active", 32'(active_bank), 32'd1);
        check("after_rst_vld_cnt", tap_vld_cnt, 32'd1);
        check("after_rst_last", 32'(last_word_cnt), 32'd4);
        read_check("after_rst_rd0", 10'h030, 32'h41);
        read_check("after_rst_rd3", 10'h033, 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end
endmodule
